// File: rtl/crc_ser_pkg.sv
// crc_ser_pkg: shared definitions for the CRC frame serializer.
//   CRC_W       - width of the downstream CRC register
//   CRC_INIT    - value the serial CRC stage takes on crc_init
//   ser_state_e - serializer FSM states
package crc_ser_pkg;

  localparam int unsigned      CRC_W    = 16;
  localparam logic [CRC_W-1:0] CRC_INIT = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_DATA,
    ST_STALL,
    ST_WAIT,
    ST_CRC,
    ST_GAP
  } ser_state_e;

endpackage

// File: rtl/crc_ser_shreg.sv
// crc_ser_shreg: loadable MSB-first shift register.
//   clk, reset  - clock, asynchronous active-low reset (clears to 0)
//   load        - load load_val (takes priority over shift)
//   shift       - shift left by one, zero fill
//   load_val    - parallel load value
//   msb         - current most significant bit
module crc_ser_shreg #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_val,
  output logic             msb
);

  logic [WIDTH-1:0] q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     q <= '0;
    else if (load)  q <= load_val;
    else if (shift) q <= {q[WIDTH-2:0], 1'b0};
  end

  assign msb = q[WIDTH-1];

endmodule

// File: rtl/crc_frame_serializer.sv
// crc_frame_serializer: takes DATA_W-bit words from a valid/ready upstream,
// shifts them out MSB first while feeding an external serial CRC stage, then
// appends the 16-bit CRC read back from that stage, followed by GAP_CYC idle
// cycles.
//   clk, reset            - clock, asynchronous active-low reset
//   s_valid/s_ready       - upstream handshake; s_data, s_last word + frame end
//   crc_in                - running CRC from the serial CRC stage
//   crc_enable/init/data  - controls of the serial CRC stage
//   tx_valid, tx_bit      - serial line output
//   tx_crc_phase          - tx_bit carries CRC bits
//   frame_done            - pulse on the final CRC bit
//   underrun_err          - only with SER_UNDERRUN_ERR_EN: sticky, set when
//                           upstream fails to supply a mid-frame word in time
module crc_frame_serializer
  import crc_ser_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned GAP_CYC = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  input  logic [CRC_W-1:0]  crc_in,
  output logic              crc_enable,
  output logic              crc_init,
  output logic              crc_data,
  output logic              tx_valid,
  output logic              tx_bit,
  output logic              tx_crc_phase,
  output logic              frame_done
`ifdef SER_UNDERRUN_ERR_EN
  ,
  output logic              underrun_err
`endif
);

  localparam int unsigned SH_W    = (DATA_W > CRC_W) ? DATA_W : CRC_W;
  localparam int unsigned CNT_M0  = (DATA_W > CRC_W) ? DATA_W : CRC_W;
  localparam int unsigned CNT_MAX = (GAP_CYC > CNT_M0) ? GAP_CYC : CNT_M0;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  ser_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;

  logic             sh_load, sh_shift, sh_msb;
  logic [SH_W-1:0]  sh_val;
  logic [SH_W-1:0]  data_ext, crc_ext;

  // Both words and CRC are left-aligned so the register MSB is always the
  // next line bit.
  assign data_ext = SH_W'(s_data) << (SH_W - DATA_W);
  assign crc_ext  = SH_W'(crc_in) << (SH_W - CRC_W);

  crc_ser_shreg #(.WIDTH(SH_W)) u_shreg (
    .clk      (clk),
    .reset    (reset),
    .load     (sh_load),
    .shift    (sh_shift),
    .load_val (sh_val),
    .msb      (sh_msb)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_d       = last_q;
    sh_load      = 1'b0;
    sh_shift     = 1'b0;
    sh_val       = data_ext;
    s_ready      = 1'b0;
    crc_enable   = 1'b0;
    crc_init     = 1'b0;
    crc_data     = 1'b0;
    tx_valid     = 1'b0;
    tx_bit       = 1'b0;
    tx_crc_phase = 1'b0;
    frame_done   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (s_valid) state_d = ST_INIT;
      end
      ST_INIT: begin
        crc_enable = 1'b1;
        crc_init   = 1'b1;
        s_ready    = 1'b1;
        cnt_d      = '0;
        if (s_valid) begin
          sh_load = 1'b1;
          last_d  = s_last;
          state_d = ST_DATA;
        end else begin
          state_d = ST_STALL;
        end
      end
      ST_DATA: begin
        crc_enable = 1'b1;
        crc_data   = sh_msb;
        tx_valid   = 1'b1;
        tx_bit     = sh_msb;
        sh_shift   = 1'b1;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          cnt_d = '0;
          if (last_q) begin
            state_d = ST_WAIT;
          end else begin
            // Next word loads over the final shift so DATA continues gapless.
            s_ready = 1'b1;
            if (s_valid) begin
              sh_load = 1'b1;
              last_d  = s_last;
            end else begin
              state_d = ST_STALL;
            end
          end
        end
      end
      ST_STALL: begin
        s_ready = 1'b1;
        if (s_valid) begin
          sh_load = 1'b1;
          last_d  = s_last;
          state_d = ST_DATA;
        end
      end
      ST_WAIT: begin
        // CRC stage has absorbed the final data bit; capture its result.
        sh_load = 1'b1;
        sh_val  = crc_ext;
        cnt_d   = '0;
        state_d = ST_CRC;
      end
      ST_CRC: begin
        tx_valid     = 1'b1;
        tx_crc_phase = 1'b1;
        tx_bit       = sh_msb;
        sh_shift     = 1'b1;
        cnt_d        = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(CRC_W - 1)) begin
          frame_done = 1'b1;
          cnt_d      = '0;
          state_d    = (GAP_CYC == 0) ? ST_IDLE : ST_GAP;
        end
      end
      ST_GAP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef SER_UNDERRUN_ERR_EN
  logic uerr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                          uerr_q <= 1'b0;
    else if (state_d == ST_STALL && state_q != ST_STALL) uerr_q <= 1'b1;
    else if (state_q == ST_INIT)                         uerr_q <= 1'b0;
  end

  assign underrun_err = uerr_q;
`endif

endmodule

// File: tb/tb_crc_frame_serializer.sv
module tb_crc_frame_serializer;
  import crc_ser_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // Shared upstream drive; sel routes it to DUT a (GAP_CYC=1) or b (GAP_CYC=0).
  logic       sel = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = '0;
  logic       s_last = 1'b0;

  logic a_s_valid, a_s_ready, a_crc_enable, a_crc_init, a_crc_data;
  logic a_tx_valid, a_tx_bit, a_tx_crc_phase, a_frame_done;
  logic b_s_valid, b_s_ready, b_crc_enable, b_crc_init, b_crc_data;
  logic b_tx_valid, b_tx_bit, b_tx_crc_phase, b_frame_done;
  logic [15:0] a_crc, b_crc;
`ifdef SER_UNDERRUN_ERR_EN
  logic a_uerr, b_uerr;
`endif

  assign a_s_valid = s_valid & ~sel;
  assign b_s_valid = s_valid & sel;

  crc_frame_serializer #(.DATA_W(8), .GAP_CYC(1)) dut (
    .clk(clk), .reset(reset),
    .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(s_data), .s_last(s_last),
    .crc_in(a_crc), .crc_enable(a_crc_enable), .crc_init(a_crc_init), .crc_data(a_crc_data),
    .tx_valid(a_tx_valid), .tx_bit(a_tx_bit), .tx_crc_phase(a_tx_crc_phase),
    .frame_done(a_frame_done)
`ifdef SER_UNDERRUN_ERR_EN
    , .underrun_err(a_uerr)
`endif
  );

  crc_frame_serializer #(.DATA_W(8), .GAP_CYC(0)) dut_g0 (
    .clk(clk), .reset(reset),
    .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(s_data), .s_last(s_last),
    .crc_in(b_crc), .crc_enable(b_crc_enable), .crc_init(b_crc_init), .crc_data(b_crc_data),
    .tx_valid(b_tx_valid), .tx_bit(b_tx_bit), .tx_crc_phase(b_tx_crc_phase),
    .frame_done(b_frame_done)
`ifdef SER_UNDERRUN_ERR_EN
    , .underrun_err(b_uerr)
`endif
  );

  // Reference serial CRC-16 stage (poly 0x1021, MSB first).
  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_crc <= CRC_INIT;
      b_crc <= CRC_INIT;
    end else begin
      if (a_crc_enable) a_crc <= a_crc_init ? CRC_INIT : crc_upd(a_crc, a_crc_data);
      if (b_crc_enable) b_crc <= b_crc_init ? CRC_INIT : crc_upd(b_crc, b_crc_data);
    end
  end

  // Observed signals of the selected DUT.
  logic m_s_ready, m_crc_enable, m_crc_init, m_tx_valid, m_tx_bit, m_tx_crc_phase, m_frame_done;
  logic [15:0] m_crc_in;
  assign m_s_ready      = sel ? b_s_ready      : a_s_ready;
  assign m_crc_enable   = sel ? b_crc_enable   : a_crc_enable;
  assign m_crc_init     = sel ? b_crc_init     : a_crc_init;
  assign m_tx_valid     = sel ? b_tx_valid     : a_tx_valid;
  assign m_tx_bit       = sel ? b_tx_bit       : a_tx_bit;
  assign m_tx_crc_phase = sel ? b_tx_crc_phase : a_tx_crc_phase;
  assign m_frame_done   = sel ? b_frame_done   : a_frame_done;
  assign m_crc_in       = sel ? b_crc          : a_crc;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  typedef struct packed {
    logic bit_v;
    logic crc_ph;
    logic done;
  } exp_t;
  exp_t exp_q[$];

  int unsigned exp_done = 0;
  int unsigned exp_init = 0;

  // Monitor state
  int unsigned cyc = 0, n_tx = 0, n_done = 0, n_init = 0, n_stall = 0;
  int unsigned last_data_cyc = 0, done_cyc = 0, last_dist = 0, crc_idx = 0;
  logic        in_gap = 1'b0, ready_gap = 1'b0;
  logic [15:0] crc_cap = '0;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!reset) begin
      in_gap  = 1'b0;
      crc_idx = 0;
    end else begin
      if (m_tx_valid) begin
        n_tx++;
        if (!m_tx_crc_phase) begin
          last_data_cyc = cyc;
        end else begin
          if (crc_idx == 0) begin
            check("wait_bubble", cyc - last_data_cyc - 1, 1);
            crc_cap = m_crc_in;
          end
          check("crc_vs_stage", m_tx_bit, crc_cap[15 - crc_idx]);
          crc_idx = (crc_idx == 15) ? 0 : crc_idx + 1;
        end
        if (exp_q.size() == 0) begin
          check("unexpected_tx", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check(e.crc_ph ? "crc_bit" : "data_bit", m_tx_bit, e.bit_v);
          check("tx_crc_phase", m_tx_crc_phase, e.crc_ph);
          check("frame_done", m_frame_done, e.done);
        end
      end else if (m_frame_done) begin
        check("frame_done_without_tx", 1, 0);
      end
      if (m_frame_done) n_done++;
      if (m_crc_init) n_init++;
      if (m_s_ready && !m_tx_valid && !m_crc_enable) n_stall++;
      if (m_frame_done) begin
        done_cyc  = cyc;
        in_gap    = 1'b1;
        ready_gap = 1'b0;
      end else if (m_crc_init && in_gap) begin
        last_dist = cyc - done_cyc;
        in_gap    = 1'b0;
      end else if (in_gap && m_s_ready) begin
        ready_gap = 1'b1;
      end
    end
  end

  function automatic logic [15:0] crc_of(input logic [7:0] b[$]);
    logic [15:0] c = CRC_INIT;
    for (int k = 0; k < b.size(); k++)
      for (int i = 7; i >= 0; i--) c = crc_upd(c, b[k][i]);
    return c;
  endfunction

  task automatic push_frame(input logic [7:0] b[$], input logic [15:0] crc);
    exp_t e;
    for (int k = 0; k < b.size(); k++)
      for (int i = 7; i >= 0; i--) begin
        e.bit_v = b[k][i]; e.crc_ph = 1'b0; e.done = 1'b0;
        exp_q.push_back(e);
      end
    for (int i = 15; i >= 0; i--) begin
      e.bit_v = crc[i]; e.crc_ph = 1'b1; e.done = (i == 0);
      exp_q.push_back(e);
    end
  endtask

  // Called at a negedge; returns at the negedge after the word is accepted.
  task automatic put_word(input logic [7:0] d, input logic last);
    int n = 0;
    s_valid = 1'b1; s_data = d; s_last = last;
    while (!m_s_ready && n < 200) begin @(negedge clk); n++; end
    check("s_ready_wait", m_s_ready, 1'b1);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b[$], input logic [15:0] crc,
                            input int stall_after, input int stall_len);
    int n;
    push_frame(b, crc);
    exp_init++;
    exp_done++;
    for (int k = 0; k < b.size(); k++) begin
      put_word(b[k], (k == b.size() - 1));
      if (k + 1 == stall_after) begin
        n = 0;
        while (!m_s_ready && n < 200) begin @(negedge clk); n++; end
        repeat (stall_len) @(negedge clk);
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin @(negedge clk); n++; end
    check("drain", exp_q.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [7:0] f_std[$]  = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    logic [7:0] f_a5[$]   = '{8'hA5};
    logic [7:0] f_four[$] = '{8'h12, 8'h34, 8'h56, 8'h78};
    logic [7:0] f_c3[$]   = '{8'hC3};
    logic [7:0] f_5a[$]   = '{8'h5A};
    logic [7:0] f_x[$]    = '{8'hDE, 8'hAD};
    logic [7:0] f_y[$]    = '{8'hBE};
    int unsigned t0, d0, i0;
    int n;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {a_s_ready, a_crc_enable, a_crc_init, a_crc_data, a_tx_valid, a_tx_bit, a_tx_crc_phase, a_frame_done},
          8'h00);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // "123456789": 72 data bits then CRC 0x29B1
    t0 = n_tx; d0 = n_done;
    send_frame(f_std, 16'h29B1, 0, 0);
    drain();
    check("std_tx_cycles", n_tx - t0, 88);
    check("std_frame_done_count", n_done - d0, 1);

    // Single word 0xA5: 1,0,1,0,0,1,0,1 then CRC
    send_frame(f_a5, crc_of(f_a5), 0, 0);
    drain();
`ifdef SER_UNDERRUN_ERR_EN
    check("underrun_clear", a_uerr, 1'b0);
`endif

    // Underrun: 3 idle upstream cycles after word 2, CRC unaffected
    t0 = n_stall;
    send_frame(f_four, crc_of(f_four), 2, 3);
    drain();
    check("stall_cycles", n_stall - t0, 3);
`ifdef SER_UNDERRUN_ERR_EN
    check("underrun_set", a_uerr, 1'b1);
`endif
    t0 = n_stall;
    send_frame(f_four, crc_of(f_four), 0, 0);
    drain();
    check("gapless_stall_cycles", n_stall - t0, 0);
`ifdef SER_UNDERRUN_ERR_EN
    check("underrun_cleared_by_init", a_uerr, 1'b0);
`endif

    // Reset during CRC bit 7 abandons the frame
    d0 = n_done;
    send_frame(f_c3, crc_of(f_c3), 0, 0);
    n = 0;
    while (!m_tx_crc_phase && n < 200) begin @(negedge clk); n++; end
    check("reach_crc_phase", m_tx_crc_phase, 1'b1);
    repeat (7) @(negedge clk);
    #2 reset = 1'b0;
    #1 check("midframe_reset_outputs",
             {a_s_ready, a_crc_enable, a_crc_init, a_crc_data, a_tx_valid, a_tx_bit, a_tx_crc_phase, a_frame_done},
             8'h00);
    exp_q.delete();
    exp_done--;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("no_done_after_abort", n_done - d0, 0);
    i0 = n_init;
    send_frame(f_5a, crc_of(f_5a), 0, 0);
    drain();
    check("single_init_after_reset", n_init - i0, 1);

    // Back-to-back frames: frame_done, GAP_CYC gap cycles, one IDLE, then INIT
    send_frame(f_x, crc_of(f_x), 0, 0);
    send_frame(f_y, crc_of(f_y), 0, 0);
    drain();
    check("gap1_distance", last_dist, 3);
    check("gap1_s_ready_low", ready_gap, 1'b0);

    sel = 1'b1;
    repeat (2) @(negedge clk);
    send_frame(f_x, crc_of(f_x), 0, 0);
    send_frame(f_y, crc_of(f_y), 0, 0);
    drain();
    check("gap0_distance", last_dist, 2);
    check("gap0_s_ready_low", ready_gap, 1'b0);

    check("total_frame_done", n_done, exp_done);
    check("total_crc_init", n_init, exp_init);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
